psk_mseq_checker: RTL and testbench
===================================

Name: psk_mseq_checker

Overview:
- Receive-side counterpart of the PSK m-sequence modulator.
- Takes one DDS phase-offset word per symbol (BPSK or QPSK), demaps it back to m-sequence bits and serialises QPSK dibits.
- Runs a self-synchronising checker for the 4-stage m-sequence b[n] = b[n-3] ^ b[n-4] (period 15) and reports lock and bit errors.
- Sits after the phase-offset bus in loopback/BIST builds of the DDS radar-wave path.

Parameters:
PHASE_W, 23, phase word width; demap uses bits [PHASE_W-1:PHASE_W-2]
LOCK_CNT, 8, consecutive correct predictions needed in CHECK to declare lock
UNLOCK_ERR, 4, consecutive mispredictions in LOCKED that drop lock
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wave_sel  in  6  6'b001000 = BPSK, 6'b010000 = QPSK, anything else = idle
clr  in  1  synchronous restart: returns to HUNT, clears history and counters
sym_valid  in  1  one-cycle strobe, phase_in valid
phase_in  in  PHASE_W  received phase offset
bit_out  out  1  recovered bit
bit_valid  out  1  bit_out/err_flag valid
err_flag  out  1  bit mismatched the prediction (CHECK/LOCKED only)
locked  out  1  checker in LOCKED
overrun  out  1  sticky: QPSK symbol arrived while second bit still pending
bit_cnt  out  CNT_W  bits checked while locked (saturating)
err_cnt  out  CNT_W  errors while locked (saturating)

Behaviour:
- Reset: all outputs 0, history 4'b0000, FSM = HUNT, no pending bit. clr has the same effect synchronously and overrides sym_valid.
- Idle wave_sel: sym_valid is ignored, FSM forced to HUNT, history cleared, counters held.
- Quadrant q = phase_in[PHASE_W-1:PHASE_W-2].
- BPSK: bit = 0 if q is 01 or 10, else 1. Example: 0 → 1, 4194303 → 0.
- QPSK: older bit = ~q[0], newer bit = ~q[1]. Examples: 1048575 → 1,1; 3145727 → 0,1; 5242879 → 1,0; 7340031 → 0,0.
- Latency, BPSK: sym_valid at cycle T → bit_valid at T+1.
- Latency, QPSK: sym_valid at cycle T → older bit at T+1, newer bit at T+2. The newer bit is held in a 1-deep pending register.
- QPSK overrun: sym_valid while the pending register is full drops the new symbol, sets overrun, and the pending bit is still emitted.
- History hist[3:0], hist[0] newest. Shifts in every emitted bit. Prediction pred = hist[2] ^ hist[3], computed before the shift.
- HUNT: count emitted bits. After 4 bits, if the updated history ≠ 0000, go to CHECK with run = 0. Otherwise keep shifting in HUNT. No err_flag in HUNT.
- CHECK: on each bit, match → run++. When run reaches LOCK_CNT, go to LOCKED. Mismatch → err_flag = 1, run = 0, back to HUNT with bit count reset to 0.
- LOCKED: bit_cnt++ every bit. On mismatch: err_flag = 1, err_cnt++, miss++. Match clears miss. miss reaching UNLOCK_ERR → HUNT.
- locked = 1 exactly while FSM = LOCKED. It updates on the same edge as bit_valid of the deciding bit.
- Counters saturate at all-ones; no wrap-around.
- Reset or clr mid-QPSK-symbol discards the pending bit.

Optional Feature:
- Macro: PSK_MSEQ_CHK_STATS_EN.
- Defined: bit_cnt and err_cnt are implemented as above.
- Undefined: both are tied to 0 and their registers are removed. Lock FSM, err_flag and overrun are unaffected.

Decomposition:
- Shared package psk_mseq_pkg holds:
  - wave-select constants WAVE_BPSK = 6'b001000, WAVE_QPSK = 6'b010000;
  - FSM state typedef {HUNT, CHECK, LOCKED};
  - LFSR seed 4'b1001 and feedback taps [3:2].
- One sub-module, psk_phase_demap: phase_in, mode → bit pair plus count (1 or 2). It is purely combinational.
- The serialiser and checker FSM stay in the top module.

Test Plan:
- BPSK lock: reset, wave_sel = 001000, feed 1,1,0,1,0,1,1,1,1,0,0,0,1,0,0 repeated as phases 0/4194303 every 10 cycles → bit_out matches; locked rises with the 12th bit_valid; err_flag never set.
- Single error when locked: flip one bit (0 ↔ 4194303) → err_flag pulse on that bit, err_cnt = 1, locked stays 1.
- Unlock: 4 consecutive flipped bits → locked falls with the 4th error; resuming the clean sequence relocks 12 bits later.
- QPSK demap/serialise: symbols 1048575, 3145727, 5242879, 7340031 → bits 11, 01, 10, 00 on consecutive cycles T+1, T+2.
- Overrun: two QPSK sym_valid pulses 1 cycle apart → second symbol dropped, overrun = 1 and sticky until clr.
- Corner cases: all-zero input (phase 4194303 forever) → stays in HUNT, locked = 0. clr mid-lock → locked = 0 and counters = 0 next cycle. Stats macro undefined → bit_cnt = err_cnt = 0.

Source files
------------

// File: rtl/psk_mseq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | psk_mseq_pkg                                                       |
// | Shared constants, types and helpers for the PSK m-sequence checker |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package psk_mseq_pkg;

   localparam logic [5:0] WAVE_BPSK = 6'b001000;
   localparam logic [5:0] WAVE_QPSK = 6'b010000;

   localparam logic [3:0] LFSR_SEED   = 4'b1001;
   localparam int         LFSR_TAP_HI = 3;
   localparam int         LFSR_TAP_LO = 2;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_BPSK = 2'd1,
      MODE_QPSK = 2'd2
   } psk_mode_t;

   function automatic psk_mode_t mode_decode(input logic [5:0] wave_sel);
      psk_mode_t m;
      case (wave_sel)
         WAVE_BPSK: m = MODE_BPSK;
         WAVE_QPSK: m = MODE_QPSK;
         default:   m = MODE_IDLE;
      endcase
      return m;
   endfunction

   // hist[0] is the newest bit, so taps [3:2] are b[n-4] and b[n-3]
   function automatic logic mseq_predict(input logic [3:0] hist);
      return hist[LFSR_TAP_HI] ^ hist[LFSR_TAP_LO];
   endfunction

endpackage
`default_nettype wire

// File: rtl/psk_mseq_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | psk_mseq_checker_if                                                |
// | Symbol input / checker status bundle for psk_mseq_checker          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface psk_mseq_checker_if #(
   parameter int PHASE_W = 23,
   parameter int CNT_W   = 16
);
   logic [5:0]         wave_sel;
   logic               clr;
   logic               sym_valid;
   logic [PHASE_W-1:0] phase_in;
   logic               bit_out;
   logic               bit_valid;
   logic               err_flag;
   logic               locked;
   logic               overrun;
   logic [CNT_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   err_cnt;

   modport master (
      output wave_sel, clr, sym_valid, phase_in,
      input  bit_out, bit_valid, err_flag, locked, overrun, bit_cnt, err_cnt
   );

   modport slave (
      input  wave_sel, clr, sym_valid, phase_in,
      output bit_out, bit_valid, err_flag, locked, overrun, bit_cnt, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/psk_phase_demap.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | psk_phase_demap                                                    |
// | Combinational quadrant demapper: phase word -> 1 (BPSK) or 2 bits  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module psk_phase_demap
   import psk_mseq_pkg::*;
#(
   parameter int PHASE_W = 23
) (
   input  logic [PHASE_W-1:0] phase_in,
   input  psk_mode_t          mode,
   output logic [1:0]         bits,     // [1] = older/only bit, [0] = newer bit
   output logic [1:0]         count
);

   logic [1:0] w_quad;
   logic       w_unused_lsbs;

   assign w_quad        = phase_in[PHASE_W-1:PHASE_W-2];
   assign w_unused_lsbs = ^phase_in[PHASE_W-3:0];

   always_comb begin
      bits  = 2'b00;
      count = 2'd0;
      case (mode)
         MODE_BPSK: begin
            bits[1] = (w_quad == 2'b00) || (w_quad == 2'b11);
            count   = 2'd1;
         end
         MODE_QPSK: begin
            bits  = {~w_quad[0], ~w_quad[1]};
            count = 2'd2;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/psk_mseq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | psk_mseq_checker                                                   |
// | PSK symbol demap/serialise + self-synchronising 4-stage m-seq      |
// | checker. Define PSK_MSEQ_CHK_STATS_EN for bit_cnt/err_cnt.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module psk_mseq_checker
   import psk_mseq_pkg::*;
#(
   parameter int PHASE_W    = 23,
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_ERR = 4,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   psk_mseq_checker_if.slave  bus
);

   localparam int c_run_w  = $clog2(LOCK_CNT + 1);
   localparam int c_miss_w = $clog2(UNLOCK_ERR + 1);
   localparam logic [c_run_w-1:0]  c_lock_run    = c_run_w'(LOCK_CNT);
   localparam logic [c_miss_w-1:0] c_unlock_miss = c_miss_w'(UNLOCK_ERR);

   psk_mode_t w_mode;
   logic [1:0] w_dm_bits;
   logic [1:0] w_dm_cnt;

   assign w_mode = mode_decode(bus.wave_sel);

   psk_phase_demap #(
      .PHASE_W (PHASE_W)
   ) u_demap (
      .phase_in (bus.phase_in),
      .mode     (w_mode),
      .bits     (w_dm_bits),
      .count    (w_dm_cnt)
   );

   logic r_pend_vld, r_pend_bit, r_overrun;
   logic r_bit_out, r_bit_valid, r_err_flag;
   logic w_pend_vld_n, w_pend_bit_n, w_overrun_n;
   logic w_emit, w_bit;

   // A pending newer bit always goes out first; a symbol colliding with it is dropped
   always_comb begin
      w_emit       = 1'b0;
      w_bit        = 1'b0;
      w_pend_vld_n = r_pend_vld;
      w_pend_bit_n = r_pend_bit;
      w_overrun_n  = r_overrun;
      if (w_mode == MODE_IDLE) begin
         w_pend_vld_n = 1'b0;
      end else if (r_pend_vld) begin
         w_emit       = 1'b1;
         w_bit        = r_pend_bit;
         w_pend_vld_n = 1'b0;
         if (bus.sym_valid) begin
            w_overrun_n = 1'b1;
         end
      end else if (bus.sym_valid) begin
         w_emit = 1'b1;
         w_bit  = w_dm_bits[1];
         if (w_dm_cnt == 2'd2) begin
            w_pend_vld_n = 1'b1;
            w_pend_bit_n = w_dm_bits[0];
         end
      end
   end

   chk_state_t            r_state, w_state_n;
   logic [3:0]            r_hist, w_hist_n;
   logic [2:0]            r_hcnt, w_hcnt_n;
   logic [c_run_w-1:0]    r_run, w_run_n;
   logic [c_miss_w-1:0]   r_miss, w_miss_n;
   logic                  w_err_n;
   logic                  w_match;

   assign w_match = (w_bit == mseq_predict(r_hist));

   always_comb begin
      w_state_n = r_state;
      w_hist_n  = r_hist;
      w_hcnt_n  = r_hcnt;
      w_run_n   = r_run;
      w_miss_n  = r_miss;
      w_err_n   = 1'b0;
      if (w_mode == MODE_IDLE) begin
         w_state_n = HUNT;
         w_hist_n  = 4'b0000;
         w_hcnt_n  = 3'd0;
         w_run_n   = '0;
         w_miss_n  = '0;
      end else if (w_emit) begin
         w_hist_n = {r_hist[2:0], w_bit};
         case (r_state)
            HUNT: begin
               if (r_hcnt != 3'd4) begin
                  w_hcnt_n = r_hcnt + 3'd1;
               end
               if ((w_hcnt_n == 3'd4) && (w_hist_n != 4'b0000)) begin
                  w_state_n = CHECK;
                  w_run_n   = '0;
               end
            end
            CHECK: begin
               if (w_match) begin
                  w_run_n = r_run + 1'b1;
                  if (w_run_n == c_lock_run) begin
                     w_state_n = LOCKED;
                     w_miss_n  = '0;
                  end
               end else begin
                  w_err_n   = 1'b1;
                  w_run_n   = '0;
                  w_hcnt_n  = 3'd0;
                  w_state_n = HUNT;
               end
            end
            LOCKED: begin
               if (w_match) begin
                  w_miss_n = '0;
               end else begin
                  w_err_n  = 1'b1;
                  w_miss_n = r_miss + 1'b1;
                  if (w_miss_n == c_unlock_miss) begin
                     w_state_n = HUNT;
                     w_hcnt_n  = 3'd0;
                     w_miss_n  = '0;
                  end
               end
            end
            default: begin
               w_state_n = HUNT;
               w_hcnt_n  = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= HUNT;
      end else if (bus.clr) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_state_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist      <= 4'b0000;
         r_hcnt      <= 3'd0;
         r_run       <= '0;
         r_miss      <= '0;
         r_pend_vld  <= 1'b0;
         r_pend_bit  <= 1'b0;
         r_overrun   <= 1'b0;
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
         r_err_flag  <= 1'b0;
      end else if (bus.clr) begin
         r_hist      <= 4'b0000;
         r_hcnt      <= 3'd0;
         r_run       <= '0;
         r_miss      <= '0;
         r_pend_vld  <= 1'b0;
         r_pend_bit  <= 1'b0;
         r_overrun   <= 1'b0;
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
         r_err_flag  <= 1'b0;
      end else begin
         r_hist      <= w_hist_n;
         r_hcnt      <= w_hcnt_n;
         r_run       <= w_run_n;
         r_miss      <= w_miss_n;
         r_pend_vld  <= w_pend_vld_n;
         r_pend_bit  <= w_pend_bit_n;
         r_overrun   <= w_overrun_n;
         r_bit_valid <= w_emit;
         r_err_flag  <= w_err_n;
         if (w_emit) begin
            r_bit_out <= w_bit;
         end
      end
   end

   assign bus.bit_out   = r_bit_out;
   assign bus.bit_valid = r_bit_valid;
   assign bus.err_flag  = r_err_flag;
   assign bus.overrun   = r_overrun;
   assign bus.locked    = (r_state == LOCKED);

`ifdef PSK_MSEQ_CHK_STATS_EN
   logic [CNT_W-1:0] r_bit_cnt, r_err_cnt;
   logic             w_cnt_bit, w_cnt_err;

   // Every bit decided while already LOCKED counts, including the one that unlocks
   assign w_cnt_bit = w_emit && (r_state == LOCKED);
   assign w_cnt_err = w_cnt_bit && !w_match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_err_cnt <= '0;
      end else if (bus.clr) begin
         r_bit_cnt <= '0;
         r_err_cnt <= '0;
      end else begin
         if (w_cnt_bit && (r_bit_cnt != {CNT_W{1'b1}})) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_cnt_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign bus.bit_cnt = r_bit_cnt;
   assign bus.err_cnt = r_err_cnt;
`else
   assign bus.bit_cnt = {CNT_W{1'b0}};
   assign bus.err_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_psk_mseq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_psk_mseq_checker                                                |
// | Directed self-checking bench for psk_mseq_checker                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_psk_mseq_checker;
   import psk_mseq_pkg::*;

   localparam int PHASE_W = 23;
   localparam int CNT_W   = 16;
`ifdef PSK_MSEQ_CHK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam logic [PHASE_W-1:0] PH_ONE  = 23'd0;
   localparam logic [PHASE_W-1:0] PH_ZERO = 23'd4194303;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;
   logic [3:0]  tbh;
   logic [14:0] seq;

   psk_mseq_checker_if #(.PHASE_W(PHASE_W), .CNT_W(CNT_W)) bus ();

   psk_mseq_checker #(
      .PHASE_W    (PHASE_W),
      .LOCK_CNT   (8),
      .UNLOCK_ERR (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // Returns one time unit after the edge that samples the symbol
   task automatic send_sym(input logic [PHASE_W-1:0] ph);
      @(posedge clk); #1;
      bus.phase_in  = ph;
      bus.sym_valid = 1'b1;
      @(posedge clk); #1;
      bus.sym_valid = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      send_sym(b ? PH_ONE : PH_ZERO);
      tbh = {tbh[2:0], b};
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1;
      bus.clr = 1'b1;
      @(posedge clk); #1;
      bus.clr = 1'b0;
      tbh = 4'b0000;
   endtask

   task automatic test_reset();
      n_chk++;
      if ({bus.bit_out, bus.bit_valid, bus.err_flag, bus.locked, bus.overrun} !== 5'b0) begin
         $display("FAIL reset_flags: got %b expected 00000",
                  {bus.bit_out, bus.bit_valid, bus.err_flag, bus.locked, bus.overrun});
      end else n_pass++;
      n_chk++;
      if (bus.bit_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin
         $display("FAIL reset_cnt: bit_cnt=%0d err_cnt=%0d expected 0/0", bus.bit_cnt, bus.err_cnt);
      end else n_pass++;
   endtask

   task automatic test_bpsk_lock();
      bus.wave_sel = WAVE_BPSK;
      for (int i = 0; i < 15; i++) begin
         send_bit(seq[14-i]);
         n_chk++;
         if (bus.bit_valid !== 1'b1 || bus.bit_out !== seq[14-i]) begin
            $display("FAIL bpsk_bit[%0d]: valid=%b bit=%b expected valid=1 bit=%b",
                     i, bus.bit_valid, bus.bit_out, seq[14-i]);
         end else n_pass++;
         n_chk++;
         if (bus.err_flag !== 1'b0) begin
            $display("FAIL bpsk_err[%0d]: err_flag=%b expected 0", i, bus.err_flag);
         end else n_pass++;
         n_chk++;
         if (bus.locked !== (i >= 11)) begin
            $display("FAIL bpsk_locked[%0d]: locked=%b expected %b", i, bus.locked, (i >= 11));
         end else n_pass++;
         if (i == 0) begin
            idle(1);
            n_chk++;
            if (bus.bit_valid !== 1'b0) begin
               $display("FAIL bpsk_valid_pulse: bit_valid=%b expected 0", bus.bit_valid);
            end else n_pass++;
            idle(7);
         end else idle(8);
      end
      n_chk++;
      if (bus.bit_cnt !== (STATS ? 16'd3 : 16'd0)) begin
         $display("FAIL bpsk_bit_cnt: got %0d expected %0d", bus.bit_cnt, (STATS ? 3 : 0));
      end else n_pass++;
   endtask

   task automatic test_single_error();
      send_bit(~seq[14]);
      n_chk++;
      if (bus.err_flag !== 1'b1 || bus.locked !== 1'b1) begin
         $display("FAIL single_err: err_flag=%b locked=%b expected 1/1", bus.err_flag, bus.locked);
      end else n_pass++;
      n_chk++;
      if (bus.err_cnt !== (STATS ? 16'd1 : 16'd0)) begin
         $display("FAIL single_err_cnt: got %0d expected %0d", bus.err_cnt, (STATS ? 1 : 0));
      end else n_pass++;
      idle(8);
      // The flipped bit feeds the predictions of the 3rd and 4th following bits
      for (int i = 1; i <= 10; i++) begin
         send_bit(seq[14-i]);
         n_chk++;
         if (bus.err_flag !== (i == 3 || i == 4) || bus.locked !== 1'b1) begin
            $display("FAIL single_err_follow[%0d]: err_flag=%b locked=%b expected %b/1",
                     i, bus.err_flag, bus.locked, (i == 3 || i == 4));
         end else n_pass++;
         idle(8);
      end
      n_chk++;
      if (bus.err_cnt !== (STATS ? 16'd3 : 16'd0) || bus.bit_cnt !== (STATS ? 16'd14 : 16'd0)) begin
         $display("FAIL single_err_stats: err_cnt=%0d bit_cnt=%0d expected %0d/%0d",
                  bus.err_cnt, bus.bit_cnt, (STATS ? 3 : 0), (STATS ? 14 : 0));
      end else n_pass++;
   endtask

   task automatic test_unlock();
      logic b;
      for (int k = 0; k < 4; k++) begin
         b = ~(tbh[2] ^ tbh[3]);
         send_bit(b);
         n_chk++;
         if (bus.err_flag !== 1'b1 || bus.locked !== (k < 3)) begin
            $display("FAIL unlock[%0d]: err_flag=%b locked=%b expected 1/%b",
                     k, bus.err_flag, bus.locked, (k < 3));
         end else n_pass++;
         idle(8);
      end
      for (int j = 0; j < 12; j++) begin
         send_bit(seq[14 - ((11 + j) % 15)]);
         n_chk++;
         if (bus.err_flag !== 1'b0 || bus.locked !== (j == 11)) begin
            $display("FAIL relock[%0d]: err_flag=%b locked=%b expected 0/%b",
                     j, bus.err_flag, bus.locked, (j == 11));
         end else n_pass++;
         idle(8);
      end
      n_chk++;
      if (bus.err_cnt !== (STATS ? 16'd7 : 16'd0) || bus.bit_cnt !== (STATS ? 16'd18 : 16'd0)) begin
         $display("FAIL unlock_stats: err_cnt=%0d bit_cnt=%0d expected %0d/%0d",
                  bus.err_cnt, bus.bit_cnt, (STATS ? 7 : 0), (STATS ? 18 : 0));
      end else n_pass++;
   endtask

   task automatic test_idle();
      bus.wave_sel = 6'b000001;
      send_sym(PH_ONE);
      n_chk++;
      if (bus.bit_valid !== 1'b0 || bus.locked !== 1'b0) begin
         $display("FAIL idle: bit_valid=%b locked=%b expected 0/0", bus.bit_valid, bus.locked);
      end else n_pass++;
      n_chk++;
      if (bus.err_cnt !== (STATS ? 16'd7 : 16'd0)) begin
         $display("FAIL idle_hold: err_cnt=%0d expected %0d", bus.err_cnt, (STATS ? 7 : 0));
      end else n_pass++;
      idle(3);
   endtask

   task automatic test_qpsk();
      logic [PHASE_W-1:0] ph [4];
      logic [1:0]         exp_bits [4];
      ph[0] = 23'd1048575; exp_bits[0] = 2'b11;
      ph[1] = 23'd3145727; exp_bits[1] = 2'b01;
      ph[2] = 23'd5242879; exp_bits[2] = 2'b10;
      ph[3] = 23'd7340031; exp_bits[3] = 2'b00;
      bus.wave_sel = WAVE_QPSK;
      for (int s = 0; s < 4; s++) begin
         send_sym(ph[s]);
         n_chk++;
         if (bus.bit_valid !== 1'b1 || bus.bit_out !== exp_bits[s][1]) begin
            $display("FAIL qpsk_old[%0d]: valid=%b bit=%b expected 1/%b",
                     s, bus.bit_valid, bus.bit_out, exp_bits[s][1]);
         end else n_pass++;
         idle(1);
         n_chk++;
         if (bus.bit_valid !== 1'b1 || bus.bit_out !== exp_bits[s][0]) begin
            $display("FAIL qpsk_new[%0d]: valid=%b bit=%b expected 1/%b",
                     s, bus.bit_valid, bus.bit_out, exp_bits[s][0]);
         end else n_pass++;
         idle(1);
         n_chk++;
         if (bus.bit_valid !== 1'b0) begin
            $display("FAIL qpsk_gap[%0d]: bit_valid=%b expected 0", s, bus.bit_valid);
         end else n_pass++;
         idle(4);
      end
      n_chk++;
      if (bus.overrun !== 1'b0) begin
         $display("FAIL qpsk_no_overrun: overrun=%b expected 0", bus.overrun);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] got;
      logic [3:0] vld;
      bus.wave_sel = WAVE_QPSK;
      send_sym(23'd1048575);
      got[3] = bus.bit_out; vld[3] = bus.bit_valid;
      idle(1);
      got[2] = bus.bit_out; vld[2] = bus.bit_valid;
      bus.phase_in  = 23'd5242879;
      bus.sym_valid = 1'b1;
      idle(1);
      bus.sym_valid = 1'b0;
      got[1] = bus.bit_out; vld[1] = bus.bit_valid;
      idle(1);
      got[0] = bus.bit_out; vld[0] = bus.bit_valid;
      n_chk++;
      if (vld !== 4'b1111 || got !== 4'b1110) begin
         $display("FAIL back_to_back: valid=%b bits=%b expected 1111/1110", vld, got);
      end else n_pass++;
      n_chk++;
      if (bus.overrun !== 1'b0) begin
         $display("FAIL back_to_back_overrun: overrun=%b expected 0", bus.overrun);
      end else n_pass++;
      idle(3);
   endtask

   task automatic test_overrun();
      bus.wave_sel  = WAVE_QPSK;
      bus.phase_in  = 23'd3145727;
      bus.sym_valid = 1'b1;
      idle(1);
      bus.phase_in  = 23'd5242879;
      n_chk++;
      if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b0) begin
         $display("FAIL overrun_old: valid=%b bit=%b expected 1/0", bus.bit_valid, bus.bit_out);
      end else n_pass++;
      idle(1);
      bus.sym_valid = 1'b0;
      n_chk++;
      if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b1 || bus.overrun !== 1'b1) begin
         $display("FAIL overrun_new: valid=%b bit=%b overrun=%b expected 1/1/1",
                  bus.bit_valid, bus.bit_out, bus.overrun);
      end else n_pass++;
      idle(1);
      n_chk++;
      if (bus.bit_valid !== 1'b0) begin
         $display("FAIL overrun_drop: bit_valid=%b expected 0", bus.bit_valid);
      end else n_pass++;
      idle(5);
      n_chk++;
      if (bus.overrun !== 1'b1) begin
         $display("FAIL overrun_sticky: overrun=%b expected 1", bus.overrun);
      end else n_pass++;
      pulse_clr();
      n_chk++;
      if (bus.overrun !== 1'b0) begin
         $display("FAIL overrun_clr: overrun=%b expected 0", bus.overrun);
      end else n_pass++;
   endtask

   task automatic test_clr_mid_qpsk();
      bus.wave_sel = WAVE_QPSK;
      send_sym(23'd1048575);
      bus.clr = 1'b1;
      idle(1);
      bus.clr = 1'b0;
      n_chk++;
      if (bus.bit_valid !== 1'b0) begin
         $display("FAIL clr_pending: bit_valid=%b expected 0", bus.bit_valid);
      end else n_pass++;
      idle(1);
      n_chk++;
      if (bus.bit_valid !== 1'b0) begin
         $display("FAIL clr_pending_late: bit_valid=%b expected 0", bus.bit_valid);
      end else n_pass++;
      tbh = 4'b0000;
   endtask

   task automatic test_all_zero();
      pulse_clr();
      bus.wave_sel = WAVE_BPSK;
      for (int i = 0; i < 20; i++) begin
         send_bit(1'b0);
         n_chk++;
         if (bus.locked !== 1'b0 || bus.err_flag !== 1'b0 || bus.bit_out !== 1'b0) begin
            $display("FAIL all_zero[%0d]: locked=%b err_flag=%b bit=%b expected 0/0/0",
                     i, bus.locked, bus.err_flag, bus.bit_out);
         end else n_pass++;
         idle(2);
      end
   endtask

   task automatic test_clr_mid_lock();
      pulse_clr();
      bus.wave_sel = WAVE_BPSK;
      for (int i = 0; i < 14; i++) begin
         send_bit(seq[14-i]);
         idle(3);
      end
      n_chk++;
      if (bus.locked !== 1'b1 || bus.bit_cnt !== (STATS ? 16'd2 : 16'd0)) begin
         $display("FAIL pre_clr: locked=%b bit_cnt=%0d expected 1/%0d",
                  bus.locked, bus.bit_cnt, (STATS ? 2 : 0));
      end else n_pass++;
      // clr and a symbol on the same edge: clr wins
      @(posedge clk); #1;
      bus.clr       = 1'b1;
      bus.sym_valid = 1'b1;
      bus.phase_in  = PH_ONE;
      idle(1);
      bus.clr       = 1'b0;
      bus.sym_valid = 1'b0;
      n_chk++;
      if (bus.locked !== 1'b0 || bus.bit_valid !== 1'b0) begin
         $display("FAIL clr_lock: locked=%b bit_valid=%b expected 0/0", bus.locked, bus.bit_valid);
      end else n_pass++;
      n_chk++;
      if (bus.bit_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin
         $display("FAIL clr_cnt: bit_cnt=%0d err_cnt=%0d expected 0/0", bus.bit_cnt, bus.err_cnt);
      end else n_pass++;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      tbh    = 4'b0000;
      seq    = 15'b110101111000100;
      rst_n         = 1'b0;
      bus.wave_sel  = 6'b000000;
      bus.clr       = 1'b0;
      bus.sym_valid = 1'b0;
      bus.phase_in  = '0;
      idle(3);
      test_reset();
      rst_n = 1'b1;
      idle(2);
      test_bpsk_lock();
      test_single_error();
      test_unlock();
      test_idle();
      test_qpsk();
      test_back_to_back();
      test_overrun();
      test_clr_mid_qpsk();
      test_all_zero();
      test_clr_mid_lock();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
